// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART frame transmitter: start, LSB-first data, optional even parity, stop
// Load/shift data register followed by the frame sequencer that owns baud timing and the serial line.

module uart_tx_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {SEL_HOLD, SEL_LOAD, SEL_SHIFT} sel_t;

  sel_t             sel;
  logic [WIDTH-1:0] shift_in;

  // Load wins over shift so an accept can never be corrupted by a stale bit-end.
  assign sel      = load ? SEL_LOAD : (shift ? SEL_SHIFT : SEL_HOLD);
  assign shift_in = {1'b0, q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_LOAD:  q <= load_data;
        SEL_SHIFT: q <= shift_in;
        default:   q <= q;
      endcase
    end
  end

endmodule

module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic                 parity_acc;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 accept;
  logic                 bit_end;
  logic                 shift_en;

  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = !tx_ready;
  assign accept   = tx_ready && tx_valid;
  assign bit_end  = (state != S_IDLE) && (baud_cnt == CNT_LAST);
  assign shift_en = (state == S_DATA) && bit_end;

  uart_tx_shift_reg #(
    .WIDTH(DATA_BITS)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (shift_en),
    .load_data(tx_data),
    .q        (shreg_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if (state == S_IDLE || bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // The line value for the next bit is registered at the boundary, so tx_out is one
  // cycle behind the state change and the start bit appears the cycle after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_idx    <= '0;
      parity_acc <= 1'b0;
      tx_out     <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_out <= 1'b1;
          if (tx_valid) begin
            state      <= S_START;
            tx_out     <= 1'b0;
            bit_idx    <= '0;
            parity_acc <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state  <= S_DATA;
            tx_out <= shreg_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_idx    <= bit_idx + 1'b1;
            // Parity accumulates from the captured bits as they leave the register.
            parity_acc <= parity_acc ^ shreg_q[0];
            if (bit_idx == IDX_LAST) begin
              if (PARITY_EN != 0) begin
                state  <= S_PARITY;
                tx_out <= parity_acc ^ shreg_q[0];
              end else begin
                state  <= S_STOP;
                tx_out <= 1'b1;
              end
            end else begin
              tx_out <= shreg_q[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state  <= S_STOP;
            tx_out <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            state   <= S_IDLE;
            tx_out  <= 1'b1;
            tx_done <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer across three configurations
// Instance 0: 4 clk/bit, 8 data, no parity. Instance 1: same with parity. Instance 2: 2 clk/bit, 5 data.

module tb_uart_tx_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data_s [3];
  logic [2:0] tx_valid_s;
  logic [2:0] tx_ready_w;
  logic [2:0] tx_out_w;
  logic [2:0] tx_busy_w;
  logic [2:0] tx_done_w;
  logic [2:0] mon_en;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0)) u_a (
    .clk(clk), .rst(rst), .tx_data(tx_data_s[0]), .tx_valid(tx_valid_s[0]),
    .tx_ready(tx_ready_w[0]), .tx_out(tx_out_w[0]), .tx_busy(tx_busy_w[0]), .tx_done(tx_done_w[0])
  );

  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1)) u_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_s[1]), .tx_valid(tx_valid_s[1]),
    .tx_ready(tx_ready_w[1]), .tx_out(tx_out_w[1]), .tx_busy(tx_busy_w[1]), .tx_done(tx_done_w[1])
  );

  uart_tx_serializer #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_EN(0)) u_c (
    .clk(clk), .rst(rst), .tx_data(tx_data_s[2][4:0]), .tx_valid(tx_valid_s[2]),
    .tx_ready(tx_ready_w[2]), .tx_out(tx_out_w[2]), .tx_busy(tx_busy_w[2]), .tx_done(tx_done_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void qpush(input int i, input logic [7:0] d);
    case (i)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qpop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Reference frame: index 0 is the first bit on the line.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input int nd, input int pe);
    logic [10:0] bits;
    logic [7:0]  m;
    int          n;
    n    = nd + 2 + pe;
    m    = 8'((1 << nd) - 1);
    bits = '1;
    bits[0] = 1'b0;
    for (int k = 0; k < nd; k++) bits[k+1] = d[k];
    if (pe != 0) bits[nd+1] = ($countones(d & m) % 2) == 1;
    bits[n-1] = 1'b1;
    return bits;
  endfunction

  task automatic monitor(input int i, input int cpb, input int nd, input int pe);
    bit          prev = 0;
    bit          skip = 0;
    bit          bad;
    bit          busy_ok;
    logic        act;
    logic [7:0]  d;
    logic [10:0] bits;
    int          n;
    forever begin
      if (!skip) @(negedge clk);
      skip = 0;
      if (rst) begin
        prev = 0;
        continue;
      end
      if (tx_busy_w[i] && !prev && mon_en[i]) begin
        if (qsize(i) == 0) begin
          chk($sformatf("u%0d_unexpected_frame", i), 1, 0);
          d = '0;
        end else begin
          d = qpop(i);
        end
        n       = nd + 2 + pe;
        bits    = frame_bits(d, nd, pe);
        busy_ok = 1;
        for (int b = 0; b < n; b++) begin
          bad = 0;
          act = bits[b];
          for (int c = 0; c < cpb; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (tx_out_w[i] !== bits[b] && !bad) begin
              bad = 1;
              act = tx_out_w[i];
            end
            if (tx_busy_w[i] !== 1'b1 || tx_done_w[i] !== 1'b0) busy_ok = 0;
          end
          chk($sformatf("u%0d_d%02h_bit%0d", i, d, b), act, bits[b]);
        end
        chk($sformatf("u%0d_d%02h_busy_frame", i, d), busy_ok, 1);
        @(negedge clk);
        chk($sformatf("u%0d_d%02h_done_pulse", i, d), tx_done_w[i], 1);
        chk($sformatf("u%0d_d%02h_ready_back", i, d), tx_ready_w[i], 1);
        chk($sformatf("u%0d_d%02h_idle_high", i, d), tx_out_w[i], 1);
        @(negedge clk);
        chk($sformatf("u%0d_d%02h_done_single", i, d), tx_done_w[i], 0);
        prev = 0;
        skip = 1;
        continue;
      end
      prev = tx_busy_w[i];
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input bit expect_frame, output time acc_t);
    acc_t = 0;
    @(negedge clk);
    tx_data_s[i]  = d;
    tx_valid_s[i] = 1'b1;
    for (int w = 0; w < 300 && tx_ready_w[i] !== 1'b1; w++) @(negedge clk);
    if (tx_ready_w[i] !== 1'b1) begin
      chk($sformatf("u%0d_accept_timeout", i), 0, 1);
      tx_valid_s[i] = 1'b0;
      return;
    end
    if (expect_frame) qpush(i, d);
    @(posedge clk);
    acc_t = $time;
    #1;
    tx_valid_s[i] = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 3000 && (q0.size() + q1.size() + q2.size() != 0 || tx_busy_w != 3'b000); w++)
      @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_u%0d_out", tag, i), tx_out_w[i], 1);
      chk($sformatf("%s_u%0d_ready", tag, i), tx_ready_w[i], 1);
      chk($sformatf("%s_u%0d_busy", tag, i), tx_busy_w[i], 0);
      chk($sformatf("%s_u%0d_done", tag, i), tx_done_w[i], 0);
    end
  endtask

  task automatic abort_test(input logic [7:0] d, input int cycles_in, input logic line_before);
    time t;
    bit  done_seen;
    mon_en[0] = 1'b0;
    send(0, d, 0, t);
    repeat (cycles_in) @(negedge clk);
    chk($sformatf("abort_%02h_line_before", d), tx_out_w[0], line_before);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs($sformatf("abort_%02h", d));
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (tx_done_w[0] !== 1'b0) done_seen = 1;
      if (c == 0) chk($sformatf("abort_%02h_ready_after", d), tx_ready_w[0], 1);
    end
    chk($sformatf("abort_%02h_no_done", d), done_seen, 0);
    mon_en[0] = 1'b1;
  endtask

  initial begin
    fork
      monitor(0, 4, 8, 0);
      monitor(1, 4, 8, 1);
      monitor(2, 2, 5, 0);
    join_none
  end

  initial begin
    time t1;
    time t2;
    rst        = 1'b0;
    tx_valid_s = '0;
    mon_en     = 3'b111;
    for (int i = 0; i < 3; i++) tx_data_s[i] = '0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    send(0, 8'hA5, 1, t1);
    send(1, 8'hA5, 1, t1);
    send(1, 8'h07, 1, t1);
    send(2, 8'h1F, 1, t1);
    drain();

    // Held valid: second accept must land exactly F+1 cycles after the first.
    @(negedge clk);
    tx_data_s[0]  = 8'h55;
    tx_valid_s[0] = 1'b1;
    qpush(0, 8'h55);
    @(posedge clk);
    t1 = $time;
    #1;
    repeat (10) @(negedge clk);
    tx_data_s[0] = 8'h0F;
    qpush(0, 8'h0F);
    for (int w = 0; w < 300 && tx_ready_w[0] !== 1'b1; w++) @(negedge clk);
    @(posedge clk);
    t2 = $time;
    #1;
    tx_valid_s[0] = 1'b0;
    chk("b2b_accept_gap_cycles", 32'((t2 - t1) / 10), 41);
    drain();

    abort_test(8'h3C, 1, 1'b0);
    abort_test(8'hFF, 18, 1'b1);
    send(0, 8'h00, 1, t1);
    drain();

    fork
      begin
        time ta;
        repeat (15) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(0, 8'($urandom), 1, ta);
        end
      end
      begin
        time tb;
        repeat (15) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(1, 8'($urandom), 1, tb);
        end
      end
      begin
        time tc;
        repeat (15) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(2, 8'($urandom), 1, tc);
        end
      end
    join
    drain();
    chk("queues_empty", q0.size() + q1.size() + q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Frame-level UART transmit engine that feeds the serial output path of the transmitter. It accepts one parallel byte per valid/ready handshake and drives `tx_out` with a start bit, the data bits LSB-first, an optional even-parity bit and one stop bit. Bit timing comes from an internal baud counter. The data bits leave through an internal load/shift register whose per-bit select is load on accept and shift on each bit boundary.

## Interface
- `CLKS_PER_BIT`, default 10416: clock cycles per serial bit (100 MHz / 9600 baud). Legal range ≥ 2.
- `DATA_BITS`, default 8: data bits per frame. Legal range 5–8.
- `PARITY_EN`, default 0: when 1, an even-parity bit is inserted after the data bits.
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `tx_data`  input  DATA_BITS  byte to send; sampled only on the accept edge.
- `tx_valid`  input  1  upstream has a byte on `tx_data`.
- `tx_ready`  output  1  block can accept a byte this cycle.
- `tx_out`  output  1  serial line; idles high.
- `tx_busy`  output  1  a frame is in progress.
- `tx_done`  output  1  one-cycle pulse when the stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx_ready`=1, `tx_out`=1, `tx_busy`=0.
  - Accept occurs on a rising edge with `tx_valid`=1 and `tx_ready`=1: load `tx_data` into the shift register, clear the baud counter and bit index, go to START.
- **START**: `tx_out`=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA**
  - `tx_out` = shift register bit 0.
  - At each bit end: shift right by one and increment the bit index.
  - After bit index DATA_BITS-1 ends, go to PARITY if PARITY_EN=1, else STOP.
- **PARITY**: `tx_out` = XOR of the captured data bits (even parity; the total count of ones, including parity, is even). Lasts CLKS_PER_BIT cycles, then go to STOP.
- **STOP**: `tx_out`=1 for CLKS_PER_BIT cycles. At stop end: pulse `tx_done`, go to IDLE.
- Baud counter
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1.
  - "Bit end" is count == CLKS_PER_BIT-1; the counter wraps to 0 there.
  - The counter runs only in non-IDLE states.
- Bit index width is $clog2(DATA_BITS+1).
- Parity is computed from the captured copy, not from live `tx_data`.
- `tx_ready` = (state == IDLE). `tx_busy` = !`tx_ready`.
- `tx_valid` while busy is ignored. The byte is not queued; upstream must hold it until accepted.
- `tx_data`/`tx_valid` changing mid-frame has no effect on the frame.
- All outputs are registered, except `tx_ready`/`tx_busy`, which are decoded from the state register.

## Timing
- Reset values (async, immediate on `rst` rise): state=IDLE, `tx_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, counter=0, shift register=0.
- Reset mid-frame aborts the frame: the line returns high at once, no `tx_done` pulse, and the block is ready on the first edge after `rst` falls.
- Accept edge T:
  - Start bit is on `tx_out` from T+1 (one cycle latency) through T+CLKS_PER_BIT.
  - Data bit k occupies cycles T+1+(k+1)·CLKS_PER_BIT … T+(k+2)·CLKS_PER_BIT.
- Frame length is F = (DATA_BITS+2+PARITY_EN)·CLKS_PER_BIT cycles.
- `tx_done` is high during cycle T+F+1, i.e. in the same cycle that `tx_ready` returns to 1.
- Back-to-back: if `tx_valid` is held, the next accept occurs on edge T+F+1. The next start bit begins at T+F+2, so there is one idle-high cycle between frames.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> `tx_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0 without waiting for a clock edge.
- CLKS_PER_BIT=4, DATA_BITS=8, PARITY_EN=0; send 0xA5 -> `tx_out` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `tx_busy` stays high for 40 cycles, then `tx_done` pulses once.
- PARITY_EN=1; send 0xA5 -> parity bit 0, frame 44 cycles. Send 0x07 -> bits 0,1,1,1,0,0,0,0,0,1(parity),1.
- Hold `tx_valid`=1 with 0x55 then 0x0F -> two frames with exactly one idle-high cycle between them. `tx_data` changed mid-frame does not alter the first frame.
- Assert `rst` during data bit 3 of 0xFF -> line high immediately, no `tx_done`. After release, 0x00 transmits as a clean 40-cycle frame (CLKS_PER_BIT=4).
- CLKS_PER_BIT=2, DATA_BITS=5; send 0x1F -> bits 0,1,1,1,1,1,1, each held 2 cycles. Baud counter wraps correctly and there is no off-by-one in bit duration.
